// File: rtl/slave_axis_skid_if_pkg.sv
// -----------------------------------------------------------------------------
// slave_axis_skid_if_pkg
// Purpose : shared constants and helpers for the AXI-Stream slave buffer.
// Contents: AXIS_DATA_W_DEFAULT - default upstream data width in bits
//           clog2()             - constant ceil(log2(n)) for sizing pointers
// -----------------------------------------------------------------------------
package slave_axis_skid_if_pkg;

  localparam int AXIS_DATA_W_DEFAULT = 128;

  // ceil(log2(n)); returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// -----------------------------------------------------------------------------
// axis_fifo_mem
// Purpose : DEPTH x WIDTH storage array, one synchronous write port and one
//           asynchronous read port. The array is deliberately not reset; the
//           owner tracks which entries hold live data.
// Ports   : clk_i   - clock (rising edge)
//           we_i    - write enable
//           waddr_i - write address
//           wdata_i - write data
//           raddr_i - read address (combinational read)
//           rdata_o - read data
// -----------------------------------------------------------------------------
module axis_fifo_mem
  import slave_axis_skid_if_pkg::*;
#(
  parameter int WIDTH = AXIS_DATA_W_DEFAULT + 1,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]          rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/slave_axis_skid_if.sv
// -----------------------------------------------------------------------------
// slave_axis_skid_if
// Purpose : AXI-Stream slave front end. Accepts beats from upstream into a
//           small first-word-fall-through FIFO and presents the oldest entry
//           to downstream logic, along with occupancy and an almost-full flag.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. Upstream write = S_AXIS_TVALID & S_AXIS_TREADY;
// downstream read = TVALID & MODULE_READY. TVALID never depends on ready, and
// S_AXIS_TREADY comes straight from a flop so it has no path from MODULE_READY.
//
// Ports   : AXIS_ACLK, AXIS_ARESET     - clock, synchronous active-high reset
//           S_AXIS_TDATA/TLAST/TVALID  - upstream beat
//           S_AXIS_TREADY              - upstream ready (registered)
//           CLK, RESET                 - wire copies of clock/reset
//           TDATA, TLAST, TVALID       - head of buffer
//           MODULE_READY               - downstream pops head entry
//           COUNT                      - occupancy, 0..DEPTH
//           ALMOST_FULL                - COUNT >= AFULL_THRESH
// -----------------------------------------------------------------------------
module slave_axis_skid_if
  import slave_axis_skid_if_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = AXIS_DATA_W_DEFAULT,
  parameter int DEPTH              = 4,
  parameter int AFULL_THRESH       = DEPTH - 1
) (
  input  logic                           AXIS_ACLK,
  input  logic                           AXIS_ARESET,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic                           S_AXIS_TLAST,
  input  logic                           S_AXIS_TVALID,
  output logic                           S_AXIS_TREADY,
  output logic                           CLK,
  output logic                           RESET,
  output logic [S_AXIS_TDATA_WIDTH-1:0]  TDATA,
  output logic                           TLAST,
  output logic                           TVALID,
  input  logic                           MODULE_READY,
  output logic [clog2(DEPTH):0]          COUNT,
  output logic                           ALMOST_FULL
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = S_AXIS_TDATA_WIDTH + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tready_q, tready_d;
  logic          wr_en, rd_en;
  logic [EW-1:0] head;

  assign CLK   = AXIS_ACLK;
  assign RESET = AXIS_ARESET;

  assign wr_en = S_AXIS_TVALID & tready_q;
  // Empty buffer ignores MODULE_READY, so a pop can never underflow.
  assign rd_en = (count_q != '0) & MODULE_READY;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Ready for the next cycle is decided from next occupancy, so a pop at
    // full reopens the input one cycle later without a combinational path.
    tready_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tready_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tready_q <= tready_d;
    end
  end

  axis_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (AXIS_ACLK),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({S_AXIS_TLAST, S_AXIS_TDATA}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign S_AXIS_TREADY = tready_q;
  assign TVALID        = (count_q != '0);
  assign TDATA         = head[S_AXIS_TDATA_WIDTH-1:0];
  assign TLAST         = head[EW-1];
  assign COUNT         = count_q;
  assign ALMOST_FULL   = (count_q >= CW'(AFULL_THRESH));

endmodule

// File: doc/slave_axis_skid_if.md
SLAVE_AXIS_SKID_IF -- requirements
Module: slave_axis_skid_if

Interface
REQ-001 SHALL have parameter S_AXIS_TDATA_WIDTH, default 128, meaning data bus width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-1, meaning occupancy at which ALMOST_FULL asserts; 1..DEPTH.
REQ-004 SHALL have port AXIS_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port AXIS_ARESET  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port S_AXIS_TDATA  in  S_AXIS_TDATA_WIDTH  upstream data.
REQ-007 SHALL have port S_AXIS_TLAST  in  1  upstream end-of-packet.
REQ-008 SHALL have port S_AXIS_TVALID  in  1  upstream valid.
REQ-009 SHALL have port S_AXIS_TREADY  out  1  upstream ready; driven directly from a flop.
REQ-010 SHALL have port CLK  out  1  copy of AXIS_ACLK for downstream modules.
REQ-011 SHALL have port RESET  out  1  copy of AXIS_ARESET for downstream modules.
REQ-012 SHALL have port TDATA  out  S_AXIS_TDATA_WIDTH  head-of-buffer data.
REQ-013 SHALL have port TLAST  out  1  head-of-buffer end-of-packet.
REQ-014 SHALL have port TVALID  out  1  buffer non-empty.
REQ-015 SHALL have port MODULE_READY  in  1  downstream accepts head entry.
REQ-016 SHALL have port COUNT  out  clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port ALMOST_FULL  out  1  COUNT >= AFULL_THRESH.

Function
REQ-018 Write SHALL occur on an edge where S_AXIS_TVALID=1 and S_AXIS_TREADY=1; entry = {S_AXIS_TLAST, S_AXIS_TDATA}.
REQ-019 Read SHALL occur on an edge where TVALID=1 and MODULE_READY=1; head entry popped.
REQ-020 Buffer SHALL be first-in first-out, first-word-fall-through; TDATA/TLAST reflect oldest entry whenever TVALID=1.
REQ-021 TVALID SHALL equal (COUNT != 0); TDATA/TLAST/TVALID SHALL have no combinational path from any input.
REQ-022 Latency: entry written at edge k SHALL appear on TDATA with TVALID=1 from edge k when buffer was empty (one cycle input-to-output).
REQ-023 COUNT SHALL update at each edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-024 S_AXIS_TREADY SHALL be registered as (COUNT_next < DEPTH); no combinational path from MODULE_READY.
REQ-025 Full (COUNT=DEPTH): S_AXIS_TREADY=0; a read at full SHALL raise S_AXIS_TREADY on the following cycle.
REQ-026 Empty: TVALID=0; simultaneous write and read cannot occur; MODULE_READY ignored.
REQ-027 Simultaneous write and read at 0<COUNT<DEPTH SHALL keep COUNT and preserve order.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH without gap or duplicate.
REQ-029 Upstream data SHALL not be dropped or duplicated under any S_AXIS_TVALID/MODULE_READY pattern.
REQ-030 CLK and RESET SHALL be pure wire copies of AXIS_ACLK and AXIS_ARESET.

Reset
REQ-031 While AXIS_ARESET=1: COUNT=0, pointers=0, TVALID=0, S_AXIS_TREADY=0, ALMOST_FULL=0.
REQ-032 S_AXIS_TREADY SHALL go to 1 on the first edge with AXIS_ARESET=0.
REQ-033 Reset mid-operation SHALL discard all entries; storage array SHALL not be reset; TDATA/TLAST don't-care while TVALID=0.

Structure
REQ-034 Shared package/header SHALL hold the clog2 constant function and the default AXIS data width.
REQ-035 Storage SHALL be sub-module axis_fifo_mem (DEPTH x (S_AXIS_TDATA_WIDTH+1), one write port, async read port); pointers, COUNT and flags in top.

Verification
REQ-036 Reset, then 4 beats 0x1..0x4 with MODULE_READY=1 -> TDATA 0x1..0x4 each one cycle after input, COUNT <= 1.
REQ-037 DEPTH=4, MODULE_READY=0, continuous TVALID -> 4 accepted, S_AXIS_TREADY=0 after 4th, COUNT=4, ALMOST_FULL from COUNT=3.
REQ-038 From full, MODULE_READY=1 one cycle -> COUNT=3, S_AXIS_TREADY=1 next cycle, head data = 2nd written beat.
REQ-039 Random TVALID/MODULE_READY 10000 cycles, counting data with TLAST every 8th -> output sequence identical, no gaps, TLAST every 8th.
REQ-040 AXIS_ARESET asserted with COUNT=3 -> next edge COUNT=0, TVALID=0, S_AXIS_TREADY=0; high again one edge after release.
